// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC and picks sequential, redirect, hold or park each cycle.
// Latency: a request sampled on a rising edge shows up on pc_o after that edge; fetch_valid_o/pc_plus4_o are combinational.
// Backpressure: stall_i holds the PC and masks every other request; HALT/ERROR park the PC with fetch_valid_o low.
//
// Ports:
//   clk_i, rst_ni          rising-edge clock, asynchronous active-low reset
//   stall_i                hold PC this cycle (highest priority in RUN)
//   branch_taken_i/_offset_i  taken branch, signed 16-bit word offset
//   jump_i/jump_index_i    absolute jump, 26-bit word index
//   jump_reg_i/reg_target_i   jump to a register byte address (must be word aligned)
//   halt_i/resume_i        enter / leave HALT
//   pc_o, pc_plus4_o       current fetch address and its successor
//   fetch_valid_o          pc_o is a real fetch this cycle
//   state_o                0=BOOT 1=RUN 2=HALT 3=ERROR
//   misaligned_o           sticky flag for a misaligned jump-register target
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BOOT_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [15:0] branch_offset_i,
  input  logic        jump_i,
  input  logic [25:0] jump_index_i,
  input  logic        jump_reg_i,
  input  logic [31:0] reg_target_i,
  input  logic        halt_i,
  input  logic        resume_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        fetch_valid_o,
  output logic [1:0]  state_o,
  output logic        misaligned_o
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // Counter only needs to reach BOOT_CYCLES-1; keep at least one bit so
  // the BOOT_CYCLES=0/1 cases still elaborate.
  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mis_q, mis_d;

  logic [31:0]   pc_plus4;
  logic [31:0]   branch_disp;
  logic          boot_done;

  assign pc_plus4    = pc_q + 32'd4;
  // Sign-extend to 32 bits first, then scale words to bytes.
  assign branch_disp = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};
  assign boot_done   = (BOOT_CYCLES == 0) || (cnt_q == CW'(BOOT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    unique case (state_q)
      ST_BOOT: begin
        cnt_d = cnt_q + CW'(1);
        if (boot_done) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stall_i) begin
          // hold everything
        end else if (halt_i) begin
          state_d = ST_HALT;
        end else if (jump_reg_i) begin
          if (reg_target_i[1:0] != 2'b00) begin
            mis_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            pc_d = reg_target_i;
          end
        end else if (jump_i) begin
          pc_d = {pc_plus4[31:28], jump_index_i, 2'b00};
        end else if (branch_taken_i) begin
          pc_d = pc_plus4 + branch_disp;
        end else begin
          pc_d = pc_plus4;
        end
      end
      ST_HALT: begin
        // Resume continues past the halting instruction; redirects are ignored.
        if (resume_i) begin
          pc_d    = pc_plus4;
          state_d = ST_RUN;
        end
      end
      ST_ERROR: begin
        mis_d = 1'b1;
      end
      default: begin
        state_d = ST_ERROR;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_plus4;
  assign fetch_valid_o = (state_q == ST_RUN) && !stall_i;
  assign state_o       = state_q;
  assign misaligned_o  = mis_q;

endmodule
